// File: rtl/book_snapshot_streamer_pkg.sv
// Shared types and constants for the order-book snapshot streamer.
package book_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } state_e;

  localparam int LEVEL_W         = 88;
  localparam int WORDS_PER_LEVEL = 3;

  // Bit layout of one book level: quantity | num_orders | price
  localparam int QTY_MSB   = 87;
  localparam int NORD_MSB  = 71;
  localparam int PRICE_MSB = 63;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hB0;

  // Header word layout: tag, sequence, drop count, number of levels in the body
  function automatic logic [31:0] header_word(input logic [7:0] magic,
                                              input logic [7:0] seq,
                                              input logic [7:0] drops,
                                              input logic [7:0] nlev);
    return {magic, seq, drops, nlev};
  endfunction

endpackage

// File: rtl/book_snapshot_streamer_if.sv
// Framed 32-bit valid/ready stream towards the HPS bridge.
interface book_snapshot_streamer_if;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_sop;
  logic        st_eop;
  logic        st_ready;

  modport master (output st_data, st_valid, st_sop, st_eop, input st_ready);
  modport slave  (input st_data, st_valid, st_sop, st_eop, output st_ready);
endinterface

// File: rtl/book_snapshot_streamer_word_select.sv
// Picks one 32-bit body word out of the frozen snapshot using a level index
// and a sub-word index (0: qty/orders, 1: price high, 2: price low).
module book_word_select
  import book_stream_pkg::*;
#(
  parameter int NUM_ENTRIES = 20,
  parameter int IDX_W       = 5
) (
  input  logic [IDX_W-1:0]   lvl_idx,
  input  logic [1:0]         sub_idx,
  input  logic [LEVEL_W-1:0] snap [NUM_ENTRIES],
  output logic [31:0]        word
);

  logic [LEVEL_W-1:0] lvl;

  // Level lookup followed by the sub-word slice
  always_comb begin
    lvl  = '0;
    word = 32'h0;
    if (int'(lvl_idx) < NUM_ENTRIES) lvl = snap[lvl_idx];
    case (sub_idx)
      2'd0:    word = {8'h00, lvl[QTY_MSB:PRICE_MSB+1]};
      2'd1:    word = lvl[PRICE_MSB:32];
      2'd2:    word = lvl[31:0];
      default: word = 32'h0;
    endcase
  end

endmodule

// File: rtl/book_snapshot_streamer.sv
// Latches a full order-book snapshot on each trigger and streams it as one
// packet: header, then three words per level (asks first, then bids).
// Triggers during a packet coalesce into one deferred snapshot; extras are
// counted as drops.
module book_snapshot_streamer
  import book_stream_pkg::*;
#(
  parameter int         NUM_LEVELS = 10,
  parameter logic [7:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               orderbook_ready,
  input  logic [LEVEL_W-1:0] ASK0, ASK1, ASK2, ASK3, ASK4,
  input  logic [LEVEL_W-1:0] ASK5, ASK6, ASK7, ASK8, ASK9,
  input  logic [LEVEL_W-1:0] BID0, BID1, BID2, BID3, BID4,
  input  logic [LEVEL_W-1:0] BID5, BID6, BID7, BID8, BID9,
  book_snapshot_streamer_if.master st,
  output logic               busy,
  output logic [7:0]         snap_seq,
  output logic [7:0]         drop_count
);

  localparam int               NUM_ENTRIES = 2 * NUM_LEVELS;
  localparam int               IDX_W       = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_LVL    = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [1:0]       LAST_SUB    = 2'(WORDS_PER_LEVEL - 1);

  logic [LEVEL_W-1:0] ask_in [10];
  logic [LEVEL_W-1:0] bid_in [10];
  logic [LEVEL_W-1:0] snap_q [NUM_ENTRIES];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] lvl_q, lvl_d;
  logic [1:0]       sub_q, sub_d;
  logic             pending_q, pending_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       seq_cnt_q, seq_cnt_d;
  logic [7:0]       snap_seq_q, snap_seq_d;
  logic [31:0]      hdr_q, hdr_d;
  logic             capture;
  logic             last_word;
  logic [31:0]      body_word;

  assign ask_in[0] = ASK0;  assign ask_in[1] = ASK1;  assign ask_in[2] = ASK2;
  assign ask_in[3] = ASK3;  assign ask_in[4] = ASK4;  assign ask_in[5] = ASK5;
  assign ask_in[6] = ASK6;  assign ask_in[7] = ASK7;  assign ask_in[8] = ASK8;
  assign ask_in[9] = ASK9;
  assign bid_in[0] = BID0;  assign bid_in[1] = BID1;  assign bid_in[2] = BID2;
  assign bid_in[3] = BID3;  assign bid_in[4] = BID4;  assign bid_in[5] = BID5;
  assign bid_in[6] = BID6;  assign bid_in[7] = BID7;  assign bid_in[8] = BID8;
  assign bid_in[9] = BID9;

  assign last_word = (state_q == ST_BODY) && (lvl_q == LAST_LVL) && (sub_q == LAST_SUB);

  // Next-state, word counters, trigger coalescing and capture decision
  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    sub_d      = sub_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    seq_cnt_d  = seq_cnt_q;
    snap_seq_d = snap_seq_q;
    hdr_d      = hdr_q;
    capture    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (orderbook_ready) capture = 1'b1;
      end
      ST_HEADER: begin
        if (st.st_ready) begin
          state_d = ST_BODY;
          lvl_d   = '0;
          sub_d   = 2'd0;
        end
      end
      ST_BODY: begin
        if (st.st_ready) begin
          if (last_word) begin
            if (pending_q || orderbook_ready) capture = 1'b1;
            else                              state_d = ST_IDLE;
          end else if (sub_q == LAST_SUB) begin
            sub_d = 2'd0;
            lvl_d = lvl_q + 1'b1;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A trigger on the EOP-accept cycle is absorbed by the recapture itself
    if (orderbook_ready && (state_q != ST_IDLE) && !(last_word && st.st_ready)) begin
      if (!pending_q)             pending_d = 1'b1;
      else if (drop_q != 8'hFF)   drop_d    = drop_q + 8'd1;
    end

    // Header is frozen at capture so it stays stable under backpressure
    if (capture) begin
      state_d    = ST_HEADER;
      pending_d  = 1'b0;
      hdr_d      = header_word(MAGIC, seq_cnt_q, drop_q, 8'(NUM_ENTRIES));
      snap_seq_d = seq_cnt_q;
      seq_cnt_d  = seq_cnt_q + 8'd1;
      lvl_d      = '0;
      sub_d      = 2'd0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Counters, coalescing flag, sequence/drop bookkeeping and header word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q      <= '0;
      sub_q      <= 2'd0;
      pending_q  <= 1'b0;
      drop_q     <= 8'd0;
      seq_cnt_q  <= 8'd0;
      snap_seq_q <= 8'd0;
      hdr_q      <= 32'h0;
    end else begin
      lvl_q      <= lvl_d;
      sub_q      <= sub_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      seq_cnt_q  <= seq_cnt_d;
      snap_seq_q <= snap_seq_d;
      hdr_q      <= hdr_d;
    end
  end

  // Snapshot registers: loaded only on capture, frozen otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) snap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        snap_q[i]              <= ask_in[i];
        snap_q[NUM_LEVELS + i] <= bid_in[i];
      end
    end
  end

  book_word_select #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_word_select (
    .lvl_idx (lvl_q),
    .sub_idx (sub_q),
    .snap    (snap_q),
    .word    (body_word)
  );

  assign st.st_valid = (state_q != ST_IDLE);
  assign st.st_sop   = (state_q == ST_HEADER);
  assign st.st_eop   = last_word;
  assign st.st_data  = (state_q == ST_HEADER) ? hdr_q :
                       (state_q == ST_BODY)   ? body_word : 32'h0;

  assign busy       = (state_q != ST_IDLE);
  assign snap_seq   = snap_seq_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_book_snapshot_streamer.sv
// Self-checking bench: a queue-of-words model of the packet stream is
// compared against the DUT every cycle, plus literal expectations per test.
module tb_book_snapshot_streamer;
  import book_stream_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig = 1'b0;
  logic [87:0] ask [10];
  logic [87:0] bid [10];
  logic        busy;
  logic [7:0]  snap_seq;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int ph = 0;

  word_t mq[$];
  word_t log_w[$];
  int    log_c[$];
  word_t t1_words[$];
  int    m_seq_next, m_last_seq, m_drop;
  bit    m_pending;

  book_snapshot_streamer_if sif();

  book_snapshot_streamer dut (
    .clk(clk), .reset(reset), .orderbook_ready(trig),
    .ASK0(ask[0]), .ASK1(ask[1]), .ASK2(ask[2]), .ASK3(ask[3]), .ASK4(ask[4]),
    .ASK5(ask[5]), .ASK6(ask[6]), .ASK7(ask[7]), .ASK8(ask[8]), .ASK9(ask[9]),
    .BID0(bid[0]), .BID1(bid[1]), .BID2(bid[2]), .BID3(bid[3]), .BID4(bid[4]),
    .BID5(bid[5]), .BID6(bid[6]), .BID7(bid[7]), .BID8(bid[8]), .BID9(bid[9]),
    .st(sif), .busy(busy), .snap_seq(snap_seq), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: a packet is the header plus 3 words per level, asks then bids
  task automatic build_packet();
    word_t w;
    logic [87:0] lv;
    w.data = {8'hB0, 8'(m_seq_next), 8'(m_drop), 8'd20};
    w.sop = 1'b1; w.eop = 1'b0;
    mq.push_back(w);
    for (int l = 0; l < 20; l++) begin
      lv = (l < 10) ? ask[l] : bid[l-10];
      w.sop = 1'b0; w.eop = 1'b0;
      w.data = {8'h00, lv[87:64]}; mq.push_back(w);
      w.data = lv[63:32];          mq.push_back(w);
      w.data = lv[31:0]; w.eop = (l == 19); mq.push_back(w);
    end
    m_last_seq = m_seq_next;
    m_seq_next = (m_seq_next + 1) % 256;
  endtask

  // Model update on each clock edge, cleared by reset
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_seq_next = 0; m_last_seq = 0; m_drop = 0; m_pending = 0;
    end else if (mq.size() == 0) begin
      if (trig) build_packet();
    end else begin
      bit acc, eop_acc;
      acc = sif.st_ready;
      eop_acc = acc && (mq.size() == 1);
      if (acc) void'(mq.pop_front());
      if (eop_acc) begin
        if (m_pending || trig) begin
          build_packet();
          m_pending = 0;
        end
      end else if (trig) begin
        if (!m_pending) m_pending = 1;
        else if (m_drop < 255) m_drop++;
      end
    end
  end

  // Compare process: mid-cycle, after inputs have settled for the next edge
  initial forever begin
    @(negedge clk); #2;
    if (reset) begin
      chk("rst_valid", 32'(sif.st_valid), 32'd0);
      chk("rst_sop",   32'(sif.st_sop),   32'd0);
      chk("rst_eop",   32'(sif.st_eop),   32'd0);
      chk("rst_data",  sif.st_data,       32'd0);
      chk("rst_busy",  32'(busy),         32'd0);
      chk("rst_seq",   32'(snap_seq),     32'd0);
      chk("rst_drop",  32'(drop_count),   32'd0);
    end else begin
      chk("valid", 32'(sif.st_valid), 32'(mq.size() != 0));
      chk("busy",  32'(busy),         32'(mq.size() != 0));
      chk("seq",   32'(snap_seq),     32'(m_last_seq));
      chk("drop",  32'(drop_count),   32'(m_drop));
      if (mq.size() != 0) begin
        chk("data", sif.st_data,       mq[0].data);
        chk("sop",  32'(sif.st_sop),   32'(mq[0].sop));
        chk("eop",  32'(sif.st_eop),   32'(mq[0].eop));
      end
      if (sif.st_valid && sif.st_ready) begin
        log_w.push_back('{sif.st_data, sif.st_sop, sif.st_eop});
        log_c.push_back(cyc);
      end
    end
  end

  // Consumer ready pattern: 0 low, 1 high, 2 repeating 1,0,0,1
  initial forever begin
    @(negedge clk); #1;
    case (ready_mode)
      0: sif.st_ready = 1'b0;
      1: sif.st_ready = 1'b1;
      default: begin
        sif.st_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        ph++;
      end
    endcase
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse();
    tick(); trig = 1'b1;
    tick(); trig = 1'b0;
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1;
    tick(); tick(); reset = 1'b0;
    log_w.delete(); log_c.delete();
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    for (n = 0; n < max; n++) begin
      tick();
      if (!sif.st_valid && mq.size() == 0) break;
    end
    chk(name, 32'(n < max), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      ask[i] = (i == 0) ? {16'd8, 8'd8, 64'd1}
                        : {16'(16'h0010 + i), 8'(i), 32'hA5A0_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
      bid[i] = {16'(16'h0100 + i), 8'(8'h20 + i), 32'hB1D0_0000 | 32'(i), 32'h0000_BEEF + 32'(i)};
    end
    ready_mode = 1;
    repeat (3) tick();
    reset = 1'b0;
    log_w.delete(); log_c.delete();

    // T1: single trigger, ready high
    pulse();
    wait_idle(200, "t1_idle");
    chk("t1_len",  32'(log_w.size()), 32'd61);
    chk("t1_w0",   log_w[0].data, 32'hB000_0014);
    chk("t1_sop",  32'(log_w[0].sop), 32'd1);
    chk("t1_w1",   log_w[1].data, 32'h0000_0808);
    chk("t1_w2",   log_w[2].data, 32'h0000_0000);
    chk("t1_w3",   log_w[3].data, 32'h0000_0001);
    chk("t1_last", log_w[60].data, 32'h0000_BEF8);
    chk("t1_eop",  32'(log_w[60].eop), 32'd1);
    chk("t1_span", 32'(log_c[60] - log_c[0]), 32'd60);
    chk("t1_busy", 32'(busy), 32'd0);
    t1_words = log_w;
    $display("T1 single packet: %0d words", log_w.size());

    // T2: same packet under 1,0,0,1 backpressure
    do_reset();
    ph = 0; ready_mode = 2;
    pulse();
    wait_idle(400, "t2_idle");
    chk("t2_len", 32'(log_w.size()), 32'd61);
    for (int i = 0; i < 61; i++) chk("t2_word", log_w[i].data, t1_words[i].data);
    $display("T2 backpressure packet: %0d words", log_w.size());

    // T3: three extra triggers during body -> one deferred packet, 2 drops
    do_reset();
    ready_mode = 1;
    pulse();
    repeat (10) tick();
    pulse(); tick(); pulse(); tick(); pulse();
    wait_idle(300, "t3_idle");
    chk("t3_len",  32'(log_w.size()), 32'd122);
    chk("t3_hdr2", log_w[61].data, 32'hB001_0214);
    chk("t3_gap",  32'(log_c[61] - log_c[60]), 32'd1);
    chk("t3_drop", 32'(drop_count), 32'd2);
    chk("t3_seq",  32'(snap_seq), 32'd1);
    $display("T3 coalesced triggers: %0d words, drop=%0d", log_w.size(), drop_count);

    // T4: trigger exactly on the EOP-accept cycle
    do_reset();
    pulse();
    begin
      int n;
      for (n = 0; n < 100; n++) begin
        if (sif.st_valid && sif.st_eop) break;
        tick();
      end
      chk("t4_eop_seen", 32'(n < 100), 32'd1);
    end
    trig = 1'b1; tick(); trig = 1'b0;
    wait_idle(200, "t4_idle");
    chk("t4_len",  32'(log_w.size()), 32'd122);
    chk("t4_hdr2", log_w[61].data, 32'hB001_0014);
    chk("t4_gap",  32'(log_c[61] - log_c[60]), 32'd1);
    chk("t4_drop", 32'(drop_count), 32'd0);
    $display("T4 trigger on eop: %0d words", log_w.size());

    // T5: input change mid-packet must not reach the in-flight packet
    do_reset();
    pulse();
    repeat (20) tick();
    ask[0][63:0] = 64'd3;
    wait_idle(200, "t5_idle1");
    chk("t5_old_price", log_w[3].data, 32'h0000_0001);
    pulse();
    wait_idle(200, "t5_idle2");
    chk("t5_new_price", log_w[64].data, 32'h0000_0003);
    ask[0][63:0] = 64'd1;
    $display("T5 frozen snapshot: %0d words", log_w.size());

    // T6: asynchronous reset mid-packet under stall
    do_reset();
    pulse();
    begin
      int n;
      for (n = 0; n < 100; n++) begin
        if (log_w.size() >= 30) break;
        tick();
      end
      chk("t6_reach30", 32'(n < 100), 32'd1);
    end
    ready_mode = 0;
    repeat (3) tick();
    chk("t6_stall_valid", 32'(sif.st_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(sif.st_valid), 32'd0);
    chk("t6_async_busy",  32'(busy), 32'd0);
    tick(); tick();
    reset = 1'b0;
    ready_mode = 1;
    log_w.delete(); log_c.delete();
    pulse();
    wait_idle(200, "t6_idle");
    chk("t6_hdr", log_w[0].data, 32'hB000_0014);
    $display("T6 async reset then fresh packet: header %h", log_w[0].data);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
